// File: rtl/mips_bus_master.sv
// Avalon-MM master front-end for the multicycle MIPS core: arbitrates fetch and load/store onto one bus.
// Optional: define MIPS_BUS_ALIGN_CHECK_EN to abort misaligned data accesses with data_err instead of ignoring low bits.
module mips_bus_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic [31:0]           fetch_data,
    output logic                  fetch_err,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [1:0]            data_size,
    input  logic                  data_signed,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    output logic                  data_ack,
    output logic [31:0]           data_rdata,
    output logic                  data_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [1:0]            off_q, off_d;
    logic                  own_data_q, own_data_d;
    logic [31:0]           result_q, result_d;
    logic                  err_q, err_d;

    logic [1:0]            req_size;
    logic [1:0]            req_off;
    logic [3:0]            req_be;
    logic [31:0]           req_wdata;
    logic                  misalign_abort;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_val;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  unused_fetch_lsb;

    assign unused_fetch_lsb = ^fetch_addr[1:0];

    // Size is normalised to 0=byte, 1=half, 2=word; the offset already has ignored low bits cleared.
    always_comb begin
        req_size  = data_size[1] ? 2'd2 : data_size;
        req_off   = '0;
        req_be    = '1;
        req_wdata = data_wdata;
        case (req_size)
            2'd0: begin
                req_off   = data_addr[1:0];
                req_be    = 4'b0001 << data_addr[1:0];
                req_wdata = {4{data_wdata[7:0]}};
            end
            2'd1: begin
                req_off   = {data_addr[1], 1'b0};
                req_be    = data_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{data_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MIPS_BUS_ALIGN_CHECK_EN
    assign misalign_abort = ((data_size == 2'b01) && data_addr[0]) ||
                            (data_size[1] && (data_addr[1:0] != 2'b00));
`else
    assign misalign_abort = 1'b0;
`endif

    always_comb begin
        rd_byte = 8'(readdata >> {off_q, 3'b000});
        rd_half = off_q[1] ? readdata[31:16] : readdata[15:0];
        case (size_q)
            2'd0:    load_val = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            2'd1:    load_val = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            default: load_val = readdata;
        endcase
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        off_d      = off_q;
        own_data_d = own_data_q;
        result_d   = result_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                err_d    = 1'b0;
                result_d = '0;
                if (data_req) begin
                    own_data_d = 1'b1;
                    addr_d     = {data_addr[ADDR_WIDTH-1:2], 2'b00};
                    be_d       = req_be;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    sgn_d      = data_signed;
                    off_d      = req_off;
                    if (misalign_abort) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = data_we ? WRITE : READ;
                    end
                end else if (fetch_req) begin
                    own_data_d = 1'b0;
                    addr_d     = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
                    be_d       = '1;
                    wdata_d    = '0;
                    size_d     = 2'd2;
                    sgn_d      = 1'b0;
                    off_d      = '0;
                    state_d    = READ;
                end
            end
            READ, WRITE: begin
                if (!waitrequest) begin
                    state_d  = DONE;
                    err_d    = 1'b0;
                    result_d = (state_q == READ) ? load_val : '0;
                end else begin
                    // Counter holds the number of stalled edges seen; abort once it reaches TIMEOUT.
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == CNT_WIDTH'(TIMEOUT))) begin
                        state_d  = DONE;
                        err_d    = 1'b1;
                        result_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            off_q      <= '0;
            own_data_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            off_q      <= off_d;
            own_data_q <= own_data_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign read       = (state_q == READ);
    assign write      = (state_q == WRITE);
    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;
    assign fetch_ack  = (state_q == DONE) && !own_data_q;
    assign data_ack   = (state_q == DONE) && own_data_q;
    assign fetch_err  = fetch_ack & err_q;
    assign data_err   = data_ack & err_q;
    assign fetch_data = fetch_ack ? result_q : '0;
    assign data_rdata = data_ack ? result_q : '0;
endmodule

// File: tb/tb_mips_bus_master.sv
// Bench for mips_bus_master: per-transaction timeline model built from the bus rules, checked every cycle.
module tb_mips_bus_master;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_ack, fetch_err;
    logic [31:0] fetch_addr, fetch_data;
    logic        data_req, data_we, data_signed, data_ack, data_err;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        busy, read, write, waitrequest;
    logic [31:0] address, writedata, readdata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_bus_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .fetch_err(fetch_err),
        .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_signed(data_signed),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
        .data_rdata(data_rdata), .data_err(data_err), .busy(busy),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    typedef struct {
        bit          isdata;
        bit          we;
        bit [1:0]    size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned stalls;
    } acc_t;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc  = 0;

    // Expected outputs per cycle of the current transaction, plus the bus inputs to present.
    logic        e_rd[64], e_wr[64], e_busy[64], e_fack[64], e_dack[64], e_err[64], e_chk[64];
    logic [31:0] e_addr[64], e_wd[64], e_data[64], in_rdata[64];
    logic [3:0]  e_be[64];
    logic        in_wait[64];
    int unsigned kk, L;

    logic        bus_seen, cap_ferr, cap_derr;
    logic [31:0] cap_addr, cap_wd, cap_fdata, cap_ddata;
    logic [3:0]  cap_be;
    int unsigned cap_fk, cap_dk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic acc_t mk(bit isd, bit we, bit [1:0] sz, bit sg, logic [31:0] ad,
                                logic [31:0] wd, logic [31:0] rd, int unsigned st);
        acc_t a;
        a.isdata = isd; a.we = we; a.size = sz; a.sgn = sg;
        a.addr = ad; a.wdata = wd; a.rdata = rd; a.stalls = st;
        return a;
    endfunction

    function automatic logic [3:0] m_be(acc_t a);
        if (!a.isdata || a.size >= 2) return 4'hF;
        if (a.size == 1) return a.addr[1] ? 4'b1100 : 4'b0011;
        case (a.addr[1:0])
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(acc_t a);
        if (a.size == 0) return {4{a.wdata[7:0]}};
        if (a.size == 1) return {2{a.wdata[15:0]}};
        return a.wdata;
    endfunction

    function automatic logic [31:0] m_load(acc_t a);
        logic [31:0] v;
        if (!a.isdata || a.size >= 2) return a.rdata;
        if (a.size == 1) begin
            v = a.addr[1] ? {16'd0, a.rdata[31:16]} : {16'd0, a.rdata[15:0]};
            if (a.sgn && v[15]) v = v | 32'hFFFF0000;
            return v;
        end
        case (a.addr[1:0])
            2'd0: v = {24'd0, a.rdata[7:0]};
            2'd1: v = {24'd0, a.rdata[15:8]};
            2'd2: v = {24'd0, a.rdata[23:16]};
            default: v = {24'd0, a.rdata[31:24]};
        endcase
        if (a.sgn && v[7]) v = v | 32'hFFFFFF00;
        return v;
    endfunction

    function automatic bit m_misaligned(acc_t a);
`ifdef MIPS_BUS_ALIGN_CHECK_EN
        if (a.isdata && a.size == 1 && a.addr[0]) return 1'b1;
        if (a.isdata && a.size >= 2 && a.addr[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void clr(int unsigned k);
        e_rd[k] = 0; e_wr[k] = 0; e_busy[k] = 0; e_fack[k] = 0; e_dack[k] = 0;
        e_err[k] = 0; e_chk[k] = 0; e_addr[k] = '0; e_wd[k] = '0; e_data[k] = '0; e_be[k] = '0;
        in_wait[k] = 1'($urandom_range(0, 1));
        in_rdata[k] = $urandom;
    endfunction

    function automatic void add_access(acc_t a);
        bit aborted = 1'b0;
        if (m_misaligned(a)) begin
            clr(kk);
            e_busy[kk] = 1; e_dack[kk] = 1; e_err[kk] = 1; e_data[kk] = '0; e_chk[kk] = 1;
            kk++;
            return;
        end
        for (int unsigned j = 0; j < 40; j++) begin
            clr(kk);
            e_busy[kk] = 1;
            e_rd[kk] = !(a.isdata && a.we);
            e_wr[kk] = a.isdata && a.we;
            e_addr[kk] = {a.addr[31:2], 2'b00};
            e_be[kk] = m_be(a);
            e_wd[kk] = m_wd(a);
            in_wait[kk] = (j < a.stalls);
            in_rdata[kk] = a.rdata;
            kk++;
            if (j >= a.stalls) break;
            if (TMO != 0 && j + 1 == TMO) begin
                aborted = 1'b1;
                break;
            end
        end
        clr(kk);
        e_busy[kk] = 1;
        if (a.isdata) e_dack[kk] = 1; else e_fack[kk] = 1;
        e_err[kk] = aborted;
        e_data[kk] = aborted ? 32'd0 : m_load(a);
        e_chk[kk] = !(a.isdata && a.we);
        kk++;
    endfunction

    task automatic compare(input int unsigned k);
        cyc = k;
        chk("read", 32'(read), 32'(e_rd[k]));
        chk("write", 32'(write), 32'(e_wr[k]));
        chk("busy", 32'(busy), 32'(e_busy[k]));
        chk("fetch_ack", 32'(fetch_ack), 32'(e_fack[k]));
        chk("data_ack", 32'(data_ack), 32'(e_dack[k]));
        if (e_rd[k] || e_wr[k]) begin
            chk("address", address, e_addr[k]);
            chk("byteenable", 32'(byteenable), 32'(e_be[k]));
        end
        if (e_wr[k]) chk("writedata", writedata, e_wd[k]);
        if (e_fack[k]) begin
            chk("fetch_err", 32'(fetch_err), 32'(e_err[k]));
            if (e_chk[k]) chk("fetch_data", fetch_data, e_data[k]);
        end
        if (e_dack[k]) begin
            chk("data_err", 32'(data_err), 32'(e_err[k]));
            if (e_chk[k]) chk("data_rdata", data_rdata, e_data[k]);
        end
    endtask

    // Entered in an IDLE cycle; requests raised now are sampled at the next edge (edge 0).
    task automatic run_txn(input acc_t d, input bit den, input acc_t f, input bit fen);
        kk = 1;
        if (den) begin
            add_access(d);
            if (fen) begin clr(kk); kk++; end
        end
        if (fen) add_access(f);
        clr(kk); kk++;
        L = kk;
        data_we = d.we; data_size = d.size; data_signed = d.sgn;
        data_addr = d.addr; data_wdata = d.wdata; fetch_addr = f.addr;
        data_req = den; fetch_req = fen;
        waitrequest = 1'($urandom_range(0, 1)); readdata = $urandom;
        bus_seen = 0; cap_addr = '0; cap_be = '0; cap_wd = '0;
        cap_fdata = '0; cap_ddata = '0; cap_ferr = 0; cap_derr = 0; cap_fk = 0; cap_dk = 0;
        for (int unsigned k = 1; k < L; k++) begin
            @(posedge clk); #1;
            compare(k);
            if ((read || write) && !bus_seen) begin
                bus_seen = 1; cap_addr = address; cap_be = byteenable; cap_wd = writedata;
            end
            if (fetch_ack && cap_fk == 0) begin cap_fk = k; cap_fdata = fetch_data; cap_ferr = fetch_err; end
            if (data_ack && cap_dk == 0) begin cap_dk = k; cap_ddata = data_rdata; cap_derr = data_err; end
            if (e_fack[k]) fetch_req = 0;
            if (e_dack[k]) data_req = 0;
            waitrequest = in_wait[k];
            readdata = in_rdata[k];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t d, f, z;
        z = mk(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0, 0);
        reset = 1; fetch_req = 0; fetch_addr = '0; data_req = 0; data_we = 0; data_size = '0;
        data_signed = 0; data_addr = '0; data_wdata = '0; waitrequest = 0; readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", 32'(read), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acks", 32'({fetch_ack, data_ack}), 0);
        chk("rst_address", address, 0);
        chk("rst_be", 32'(byteenable), 0);
        chk("rst_wd", writedata, 0);
        reset = 0;
        @(posedge clk); #1;

        f = mk(0, 0, 2'd2, 0, 32'hBFC00004, 32'h0, 32'h24020005, 0);
        run_txn(z, 0, f, 1);
        chk("tp1_addr", cap_addr, 32'hBFC00004);
        chk("tp1_ack_cycle", cap_fk, 2);
        chk("tp1_data", cap_fdata, 32'h24020005);
        chk("tp1_err", 32'(cap_ferr), 0);

        d = mk(1, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FFFF7F, 0);
        run_txn(d, 1, z, 0);
        chk("tp2_be", 32'(cap_be), 32'h8);
        chk("tp2_signed", cap_ddata, 32'hFFFFFF80);
        d.sgn = 0;
        run_txn(d, 1, z, 0);
        chk("tp2_unsigned", cap_ddata, 32'h00000080);

        d = mk(1, 1, 2'd1, 0, 32'h2002, 32'hABCD1234, 32'h0, 3);
        run_txn(d, 1, z, 0);
        chk("tp3_wd", cap_wd, 32'h12341234);
        chk("tp3_be", 32'(cap_be), 32'hC);
        chk("tp3_ack_cycle", cap_dk, 5);

        d = mk(1, 0, 2'd2, 0, 32'h3000, 32'h0, 32'hCAFEF00D, 0);
        f = mk(0, 0, 2'd2, 0, 32'h400, 32'h0, 32'h12345678, 0);
        run_txn(d, 1, f, 1);
        chk("tp4_first_addr", cap_addr, 32'h3000);
        chk("tp4_dack_cycle", cap_dk, 2);
        chk("tp4_fack_cycle", cap_fk, 5);

        d = mk(1, 0, 2'd2, 0, 32'h5000, 32'h0, 32'h55AA55AA, 10);
        run_txn(d, 1, z, 0);
        chk("tp5_ack_cycle", cap_dk, 5);
        chk("tp5_err", 32'(cap_derr), 1);
        chk("tp5_data", cap_ddata, 0);

        d = mk(1, 0, 2'd2, 0, 32'h1001, 32'h0, 32'h11223344, 0);
        run_txn(d, 1, z, 0);
`ifdef MIPS_BUS_ALIGN_CHECK_EN
        chk("tp6_no_bus", 32'(bus_seen), 0);
        chk("tp6_ack_cycle", cap_dk, 1);
        chk("tp6_err", 32'(cap_derr), 1);
`else
        chk("tp6_addr", cap_addr, 32'h1000);
        chk("tp6_be", 32'(cap_be), 32'hF);
        chk("tp6_err", 32'(cap_derr), 0);
`endif

        fetch_addr = 32'h600; fetch_req = 1; waitrequest = 1;
        @(posedge clk); #1;
        chk("tp7_read_before", 32'(read), 1);
        reset = 1; fetch_req = 0;
        @(posedge clk); #1;
        chk("tp7_read_after", 32'(read), 0);
        chk("tp7_busy_after", 32'(busy), 0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("tp7_no_ack", 32'({fetch_ack, data_ack}), 0);
        end
        waitrequest = 0;
        f = mk(0, 0, 2'd2, 0, 32'h604, 32'h0, 32'h0BADF00D, 1);
        run_txn(z, 0, f, 1);
        chk("tp7_recover_cycle", cap_fk, 3);
        chk("tp7_recover_data", cap_fdata, 32'h0BADF00D);

        for (int n = 0; n < 200; n++) begin
            bit den, fen;
            den = 1'($urandom_range(0, 1));
            fen = den ? 1'($urandom_range(0, 1)) : 1'b1;
            d = mk(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom_range(0, 6));
            f = mk(0, 0, 2'd2, 0, $urandom, 32'h0, $urandom, $urandom_range(0, 6));
            run_txn(d, den, f, fen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mips_bus_master.md
Name: mips_bus_master

Overview:
- Avalon-MM master front-end for the multicycle MIPS core.
- Arbitrates one instruction-fetch channel and one load/store data channel onto a single Avalon bus.
- Generates byteenable and lane placement for byte, half and word accesses; sign- or zero-extends load data.
- Enforces one outstanding transaction, with an optional waitrequest timeout.

Parameters:
- ADDR_WIDTH, 32, width of all address ports; the Avalon address is word-aligned.
- TIMEOUT, 0, maximum cycles of waitrequest stall before abort; 0 disables the timeout.
- CNT_WIDTH, 8, width of the stall counter; TIMEOUT must be below 2**CNT_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; held until fetch_ack.
- fetch_addr  in  ADDR_WIDTH  fetch byte address.
- fetch_ack  out  1  one-cycle completion pulse.
- fetch_data  out  32  instruction word, valid with fetch_ack.
- fetch_err  out  1  timeout abort, valid with fetch_ack.
- data_req  in  1  load/store request; held until data_ack.
- data_we  in  1  1 = store, 0 = load.
- data_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- data_signed  in  1  sign-extend load result.
- data_addr  in  ADDR_WIDTH  data byte address.
- data_wdata  in  32  store data, right-justified.
- data_ack  out  1  one-cycle completion pulse.
- data_rdata  out  32  extended load result, valid with data_ack.
- data_err  out  1  timeout or misalignment, valid with data_ack.
- busy  out  1  high in any state other than IDLE.
- address  out  ADDR_WIDTH  Avalon address, bits [1:0] always 0.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- waitrequest  in  1  Avalon stall.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte lanes.
- readdata  in  32  Avalon read data.

Behaviour:
- Reset: all outputs 0, state IDLE, stall counter 0.
  - Reset during a transaction drops read/write at the next edge.
  - The in-flight access is discarded and no ack is issued.
- States are IDLE, READ, WRITE and DONE.
- IDLE:
  - If data_req is high, latch the data channel; data has priority over fetch.
  - Otherwise, if fetch_req is high, latch the fetch channel.
  - Next state is READ, or WRITE for a store.
  - address, byteenable, writedata and read/write are registered and held constant until completion.
- READ/WRITE:
  - On an edge where waitrequest is 0, the access completes: readdata is captured and the next state is DONE.
  - While waitrequest is 1 the stall counter increments.
  - If TIMEOUT is nonzero and the counter equals TIMEOUT, abort to DONE with err=1 and data 0.
- DONE:
  - The owning channel's ack is high for exactly this cycle; the other ack stays 0.
  - read and write are 0.
  - No request is sampled; next state is IDLE.
  - Requesters drop req on seeing ack.
- Minimum latency: req sampled at edge 0, bus cycle 1, ack cycle 2.
- Lanes are little-endian; off = addr[1:0].
  - Byte: byteenable = 1<<off; writedata = {4{wdata[7:0]}}; load takes readdata[8*off +: 8].
  - Half: byteenable = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}; load takes the selected 16 bits.
  - Word: byteenable = 1111.
  - Load extension follows data_signed.
  - Fetch is always a word access; fetch_addr[1:0] is ignored.
- Misalignment (half with addr[0]=1, or word with addr[1:0]!=0): handling is defined by the optional feature below.
- Fetch and data requests rising in the same IDLE cycle: data is served first; fetch is served on the following IDLE.

Optional Feature:
- Macro: MIPS_BUS_ALIGN_CHECK_EN.
- Defined: a misaligned data access issues no bus cycle; IDLE goes directly to DONE with data_err=1 and data_rdata=0.
- Undefined: offending low address bits are ignored.
  - Half uses addr[1] only.
  - Word uses offset 0.
  - No error is raised.

Test Plan:
- Fetch at 0xBFC00004 with waitrequest low, readdata=0x24020005 -> read=1 and address=0xBFC00004 in cycle 1; fetch_ack=1 and fetch_data=0x24020005 in cycle 2; fetch_err=0.
- Signed byte load at 0x1003, readdata=0x80FF_FF7F -> byteenable=1000; data_rdata=0xFFFFFF80. Unsigned variant -> 0x00000080.
- Half store 0xABCD1234 at 0x2002 -> write=1, writedata=0x12341234, byteenable=1100. Hold waitrequest high 3 cycles -> signals stable throughout; data_ack arrives 1 cycle after waitrequest falls.
- Fetch and data load requested in the same cycle -> data bus cycle first and data_ack first; fetch bus cycle begins after DONE→IDLE.
- TIMEOUT=4, waitrequest stuck high on a read -> abort after 4 stall cycles; ack=1, err=1, data=0; read=0 in DONE.
- Word load at 0x1001:
  - With the macro -> no read pulse; data_ack=1 and data_err=1 on cycle 1.
  - Without the macro -> address 0x1000, byteenable=1111.
- Reset asserted mid-READ -> read=0 next cycle; no ack; the next fetch proceeds normally.
